// File: rtl/quad_pkg.sv
// ============================================================================
// Module   : quad_pkg
// Brief    : Shared FSM state type, direction levels and quadrature sequence
//            helpers for quadrature_step_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package quad_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    // Up: 00 -> 10 -> 11 -> 01 -> 00 ({A,B}, A leads B)
    function automatic logic [1:0] up_next(input logic [1:0] ab);
        case (ab)
            AB_00:   up_next = AB_10;
            AB_10:   up_next = AB_11;
            AB_11:   up_next = AB_01;
            default: up_next = AB_00;
        endcase
    endfunction

    // Down: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] down_next(input logic [1:0] ab);
        case (ab)
            AB_00:   down_next = AB_01;
            AB_01:   down_next = AB_11;
            AB_11:   down_next = AB_10;
            default: down_next = AB_00;
        endcase
    endfunction

endpackage : quad_pkg

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// Module   : sync_chain
// Brief    : STAGES-deep, 2-bit-wide asynchronous-reset synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= 2'b00;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule : sync_chain

`default_nettype wire

// File: rtl/quadrature_step_gen.sv
// ============================================================================
// Module   : quadrature_step_gen
// Brief    : Quadrature encoder front end producing step/direction for an
//            up/down counter, with illegal-transition flag and tally.
// Options  : QUAD_GLITCH_FILTER_EN - adds a FILTER_LEN-cycle stability filter
//            between the synchronizer and the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quadrature_step_gen
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 4,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int c_FILT_EN = 1;
`else
    localparam int c_FILT_EN = 0;
`endif

    // INIT must outlast every pipeline stage feeding the decoder.
    localparam int c_INIT_WAIT = SYNC_STAGES + c_FILT_EN * FILTER_LEN;
    localparam int c_ICW       = $clog2(c_INIT_WAIT + 1);

    logic [1:0] ab_s;
    logic [1:0] ab_dec;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   ({a_in, b_in}),
        .q_o   (ab_s)
    );

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int c_FCW = $clog2(FILTER_LEN + 1);

    logic [1:0]       cand_q;
    logic [1:0]       filt_q;
    logic [c_FCW-1:0] stab_q;

    // cand_q/stab_q track the current run; filt_q moves only once a run
    // reaches FILTER_LEN samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q <= 2'b00;
            filt_q <= 2'b00;
            stab_q <= c_FCW'(FILTER_LEN);
        end else if (ab_s != cand_q) begin
            cand_q <= ab_s;
            stab_q <= c_FCW'(1);
            if (FILTER_LEN == 1) begin
                filt_q <= ab_s;
            end
        end else if (stab_q != c_FCW'(FILTER_LEN)) begin
            stab_q <= stab_q + 1'b1;
            if (stab_q + 1'b1 == c_FCW'(FILTER_LEN)) begin
                filt_q <= cand_q;
            end
        end
    end

    assign ab_dec = filt_q;
`else
    assign ab_dec = ab_s;
`endif

    state_t           state_q;
    logic [c_ICW-1:0] init_cnt_q;
    logic [1:0]       prev_ab_q;
    logic             step_q;
    logic             dir_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_ab_q  <= 2'b00;
            step_q     <= 1'b0;
            dir_q      <= DIR_DOWN;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == c_ICW'(c_INIT_WAIT)) begin
                        prev_ab_q <= ab_dec;
                        state_q   <= ST_TRACK;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_TRACK: begin
                    prev_ab_q <= ab_dec;
                    if (ab_dec == prev_ab_q) begin
                        step_q <= 1'b0;
                    end else if (ab_dec == up_next(prev_ab_q)) begin
                        step_q <= 1'b1;
                        dir_q  <= DIR_UP;
                    end else if (ab_dec == down_next(prev_ab_q)) begin
                        step_q <= 1'b1;
                        dir_q  <= DIR_DOWN;
                    end else begin
                        err_q <= 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign step    = step_q;
    assign up_down = dir_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule : quadrature_step_gen

`default_nettype wire
